easyaxi_mst_rd_engine: RTL and testbench
========================================

EASYAXI_MST_RD_ENGINE -- requirements
Module: easyaxi_mst_rd_engine

Interface
REQ-001 SHALL have parameter OST_DEPTH, default 8, meaning outstanding slot count; power of 2, range 2..16, 2**$clog2(OST_DEPTH) <= 2**`AXI_ID_W.
REQ-002 SHALL have parameter MAX_BURST_LEN, default 8, meaning beats buffered per slot; power of 2, range 1..16.
REQ-003 SHALL derive SLOT_W = $clog2(OST_DEPTH) and LEN_W = max(1,$clog2(MAX_BURST_LEN)).
REQ-004 SHALL use one clock and an asynchronous, active-high reset: clk in 1 (all flops rising-edge); rst in 1 (asynchronous active-high reset).
REQ-005 SHALL have command port: cmd_valid in 1; cmd_ready out 1; cmd_addr in `AXI_ADDR_W; cmd_len in LEN_W (beats-1); cmd_size in `AXI_SIZE_W; cmd_burst in `AXI_BURST_W; cmd_user in `AXI_USER_W.
REQ-006 SHALL have AR master port: axi_mst_arvalid out 1; axi_mst_arready in 1; axi_mst_arid out `AXI_ID_W; axi_mst_araddr out `AXI_ADDR_W; axi_mst_arlen out `AXI_LEN_W; axi_mst_arsize out `AXI_SIZE_W; axi_mst_arburst out `AXI_BURST_W; axi_mst_aruser out `AXI_USER_W.
REQ-007 SHALL have R master port: axi_mst_rvalid in 1; axi_mst_rready out 1; axi_mst_rid in `AXI_ID_W; axi_mst_rdata in `AXI_DATA_W; axi_mst_rresp in `AXI_RESP_W; axi_mst_rlast in 1; axi_mst_ruser in `AXI_USER_W (unused).
REQ-008 SHALL have completion port: cmp_valid out 1; cmp_ready in 1; cmp_slot out SLOT_W; cmp_data out `AXI_DATA_W*MAX_BURST_LEN (beat k at bits [k*DATA_W +: DATA_W]); cmp_beats out LEN_W+1; cmp_resp out `AXI_RESP_W; cmp_err out 1.
REQ-009 SHALL have status: ost_cnt out SLOT_W+1 (slots in use); proto_err out 1 (sticky).

Function
REQ-010 Slots SHALL form a ring: alloc_ptr, issue_ptr, retire_ptr, each SLOT_W bits, wrapping OST_DEPTH-1 -> 0.
REQ-011 Slot state machine SHALL be FREE -> PEND (cmd accept) -> ISSUED (AR handshake) -> DONE (R beat with rlast) -> FREE (completion handshake).
REQ-012 cmd_ready SHALL equal (ost_cnt != OST_DEPTH), from registered state only; no same-cycle reuse of a slot retiring that cycle.
REQ-013 On cmd_valid & cmd_ready, slot alloc_ptr SHALL capture the payload, clear beat counter, resp and error, enter PEND; alloc_ptr +1.
REQ-014 axi_mst_arvalid SHALL be 1 when slot issue_ptr is PEND; earliest one cycle after command acceptance.
REQ-015 AR fields SHALL come from slot issue_ptr: arid = zero-extended issue_ptr, arlen = zero-extended cmd_len, others verbatim; stable while arvalid & ~arready.
REQ-016 On AR handshake slot SHALL enter ISSUED, issue_ptr +1; AR issue strictly in allocation order.
REQ-017 axi_mst_rready SHALL be constant 1.
REQ-018 Each R beat SHALL address slot rid[SLOT_W-1:0]; interleaving across IDs SHALL be accepted.
REQ-019 Beat SHALL be written at index beat_cnt; beat_cnt +1; resp held = max(held, rresp) numerically.
REQ-020 On rlast, slot SHALL enter DONE; cmp_err set if beats received != cmd_len+1.
REQ-021 Beats with beat_cnt = MAX_BURST_LEN SHALL be discarded and set slot error.
REQ-022 Beat to slot not ISSUED, or rid upper bits [`AXI_ID_W-1:SLOT_W] nonzero, SHALL be dropped and set proto_err; cleared only by reset.
REQ-023 cmp_valid SHALL be 1 when slot retire_ptr is DONE; earliest one cycle after its rlast beat; completions strictly in allocation order regardless of R order.
REQ-024 cmp_* SHALL be stable while cmp_valid & ~cmp_ready; cmp_beats = beats stored; unwritten beats read 0.
REQ-025 On cmp handshake slot SHALL become FREE, retire_ptr +1.
REQ-026 ost_cnt SHALL +1 on accept, -1 on retire, unchanged when both occur in the same cycle.

Reset
REQ-027 While rst = 1, all slots SHALL be FREE, pointers, ost_cnt, proto_err 0, cmd_ready 0; arvalid, cmp_valid, cmp_err 0; all payload/data 0.
REQ-028 Reset asserted mid-operation SHALL abandon all slots; R beats arriving after release SHALL trigger REQ-022.
REQ-029 cmd_ready SHALL be 1 from the first clock edge after rst deasserts.

Verification
REQ-030 Single: cmd addr 0x100 len 3 INCR 4B; arready=1; 4 beats rid 0 -> AR arid 0 arlen 3 one cycle after accept; cmp_valid one cycle after rlast, cmp_beats 4, cmp_resp OKAY, cmp_err 0.
REQ-031 Reorder: 3 cmds (slots 0,1,2); R for rid 2, then 0, then 1 -> cmp order slots 0,1,2; correct per-slot data.
REQ-032 Full: OST_DEPTH=8, arready=0, 9 cmds -> cmd_ready 0 after 8th, ost_cnt 8; retire one -> cmd_ready 1 next cycle.
REQ-033 Error: rid 1 burst with beat 2 rresp SLVERR, rlast on beat 3 of len 3 -> cmp_resp SLVERR, cmp_beats 3, cmp_err 1.
REQ-034 Protocol: rvalid rid 5 with no outstanding slot -> proto_err 1, sticky until rst.
REQ-035 Backpressure/wrap: cmp_ready toggled, 20 cmds -> cmp fields stable when stalled, pointers wrap, all 20 completions in order.

Source files
------------

// File: rtl/easyaxi_mst_rd_engine.sv
// AXI read master engine: ring of outstanding slots, in-order AR issue,
// R beats collected per ID in any order, completions retired in allocation order.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 4
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module easyaxi_mst_rd_engine #(
    parameter int OST_DEPTH     = 8,
    parameter int MAX_BURST_LEN = 8,
    localparam int SLOT_W = $clog2(OST_DEPTH),
    localparam int LEN_W  = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [`AXI_ADDR_W-1:0]                cmd_addr,
    input  logic [LEN_W-1:0]                      cmd_len,
    input  logic [`AXI_SIZE_W-1:0]                cmd_size,
    input  logic [`AXI_BURST_W-1:0]               cmd_burst,
    input  logic [`AXI_USER_W-1:0]                cmd_user,
    output logic                                  axi_mst_arvalid,
    input  logic                                  axi_mst_arready,
    output logic [`AXI_ID_W-1:0]                  axi_mst_arid,
    output logic [`AXI_ADDR_W-1:0]                axi_mst_araddr,
    output logic [`AXI_LEN_W-1:0]                 axi_mst_arlen,
    output logic [`AXI_SIZE_W-1:0]                axi_mst_arsize,
    output logic [`AXI_BURST_W-1:0]               axi_mst_arburst,
    output logic [`AXI_USER_W-1:0]                axi_mst_aruser,
    input  logic                                  axi_mst_rvalid,
    output logic                                  axi_mst_rready,
    input  logic [`AXI_ID_W-1:0]                  axi_mst_rid,
    input  logic [`AXI_DATA_W-1:0]                axi_mst_rdata,
    input  logic [`AXI_RESP_W-1:0]                axi_mst_rresp,
    input  logic                                  axi_mst_rlast,
    input  logic [`AXI_USER_W-1:0]                axi_mst_ruser,
    output logic                                  cmp_valid,
    input  logic                                  cmp_ready,
    output logic [SLOT_W-1:0]                     cmp_slot,
    output logic [`AXI_DATA_W*MAX_BURST_LEN-1:0]  cmp_data,
    output logic [LEN_W:0]                        cmp_beats,
    output logic [`AXI_RESP_W-1:0]                cmp_resp,
    output logic                                  cmp_err,
    output logic [SLOT_W:0]                       ost_cnt,
    output logic                                  proto_err
);
    localparam int DATA_W = `AXI_DATA_W;
    localparam logic [SLOT_W:0] FULL_CNT = OST_DEPTH[SLOT_W:0];
    localparam logic [LEN_W:0]  MAX_CNT  = MAX_BURST_LEN[LEN_W:0];

    typedef enum logic [1:0] {S_FREE, S_PEND, S_ISSUED, S_DONE} slot_state_t;

    slot_state_t              st     [OST_DEPTH];
    logic [`AXI_ADDR_W-1:0]   s_addr [OST_DEPTH];
    logic [LEN_W-1:0]         s_len  [OST_DEPTH];
    logic [`AXI_SIZE_W-1:0]   s_size [OST_DEPTH];
    logic [`AXI_BURST_W-1:0]  s_burst[OST_DEPTH];
    logic [`AXI_USER_W-1:0]   s_user [OST_DEPTH];
    logic [LEN_W:0]           s_cnt  [OST_DEPTH];
    logic [`AXI_RESP_W-1:0]   s_resp [OST_DEPTH];
    logic                     s_err  [OST_DEPTH];
    logic [DATA_W-1:0]        s_data [OST_DEPTH][MAX_BURST_LEN];

    logic [SLOT_W-1:0] alloc_ptr, issue_ptr, retire_ptr;
    logic              rdy_q;
    logic              cmd_fire, ar_fire, cmp_fire;
    logic [SLOT_W-1:0] r_slot;
    logic              r_bad, r_ovf, r_len_err, r_err_nxt;
    logic [LEN_W:0]    r_cnt_nxt;
    logic              unused_ruser;

    assign unused_ruser = ^axi_mst_ruser;

    // rdy_q keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = rdy_q && (ost_cnt != FULL_CNT);
    assign cmd_fire  = cmd_valid && cmd_ready;

    assign axi_mst_arvalid = (st[issue_ptr] == S_PEND);
    assign axi_mst_arid    = `AXI_ID_W'(issue_ptr);
    assign axi_mst_araddr  = s_addr[issue_ptr];
    assign axi_mst_arlen   = `AXI_LEN_W'(s_len[issue_ptr]);
    assign axi_mst_arsize  = s_size[issue_ptr];
    assign axi_mst_arburst = s_burst[issue_ptr];
    assign axi_mst_aruser  = s_user[issue_ptr];
    assign ar_fire         = axi_mst_arvalid && axi_mst_arready;
    assign axi_mst_rready  = 1'b1;

    assign r_slot    = axi_mst_rid[SLOT_W-1:0];
    assign r_bad     = ((axi_mst_rid >> SLOT_W) != '0) || (st[r_slot] != S_ISSUED);
    assign r_ovf     = (s_cnt[r_slot] == MAX_CNT);
    assign r_cnt_nxt = r_ovf ? s_cnt[r_slot] : s_cnt[r_slot] + 1'b1;
    assign r_len_err = (r_cnt_nxt != ({1'b0, s_len[r_slot]} + 1'b1));
    assign r_err_nxt = s_err[r_slot] || r_ovf || (axi_mst_rlast && r_len_err);

    assign cmp_valid = (st[retire_ptr] == S_DONE);
    assign cmp_slot  = retire_ptr;
    assign cmp_beats = s_cnt[retire_ptr];
    assign cmp_resp  = s_resp[retire_ptr];
    assign cmp_err   = cmp_valid && s_err[retire_ptr];
    assign cmp_fire  = cmp_valid && cmp_ready;

    always_comb begin
        cmp_data = '0;
        for (int unsigned k = 0; k < MAX_BURST_LEN; k++)
            cmp_data[k*DATA_W +: DATA_W] = s_data[retire_ptr][k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < OST_DEPTH; s++) begin
                st[s]      <= S_FREE;
                s_addr[s]  <= '0;
                s_len[s]   <= '0;
                s_size[s]  <= '0;
                s_burst[s] <= '0;
                s_user[s]  <= '0;
                s_cnt[s]   <= '0;
                s_resp[s]  <= '0;
                s_err[s]   <= 1'b0;
                for (int unsigned k = 0; k < MAX_BURST_LEN; k++)
                    s_data[s][k] <= '0;
            end
            alloc_ptr  <= '0;
            issue_ptr  <= '0;
            retire_ptr <= '0;
            ost_cnt    <= '0;
            proto_err  <= 1'b0;
            rdy_q      <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (cmd_fire) begin
                st[alloc_ptr]      <= S_PEND;
                s_addr[alloc_ptr]  <= cmd_addr;
                s_len[alloc_ptr]   <= cmd_len;
                s_size[alloc_ptr]  <= cmd_size;
                s_burst[alloc_ptr] <= cmd_burst;
                s_user[alloc_ptr]  <= cmd_user;
                s_cnt[alloc_ptr]   <= '0;
                s_resp[alloc_ptr]  <= '0;
                s_err[alloc_ptr]   <= 1'b0;
                for (int unsigned k = 0; k < MAX_BURST_LEN; k++)
                    s_data[alloc_ptr][k] <= '0;
                alloc_ptr <= alloc_ptr + 1'b1;
            end
            if (ar_fire) begin
                st[issue_ptr] <= S_ISSUED;
                issue_ptr     <= issue_ptr + 1'b1;
            end
            // A valid beat only ever targets an ISSUED slot, so it never
            // collides with the alloc/issue/retire slot written above.
            if (axi_mst_rvalid) begin
                if (r_bad) begin
                    proto_err <= 1'b1;
                end else begin
                    if (!r_ovf) begin
                        s_data[r_slot][s_cnt[r_slot][LEN_W-1:0]] <= axi_mst_rdata;
                        if (axi_mst_rresp > s_resp[r_slot])
                            s_resp[r_slot] <= axi_mst_rresp;
                    end
                    s_cnt[r_slot] <= r_cnt_nxt;
                    s_err[r_slot] <= r_err_nxt;
                    if (axi_mst_rlast)
                        st[r_slot] <= S_DONE;
                end
            end
            if (cmp_fire) begin
                st[retire_ptr] <= S_FREE;
                retire_ptr     <= retire_ptr + 1'b1;
            end
            if (cmd_fire && !cmp_fire)
                ost_cnt <= ost_cnt + 1'b1;
            else if (!cmd_fire && cmp_fire)
                ost_cnt <= ost_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_easyaxi_mst_rd_engine.sv
// Randomized bench for easyaxi_mst_rd_engine against a per-slot transaction model.
`ifndef AXI_ID_W
`define AXI_ID_W 4
`endif
`ifndef AXI_ADDR_W
`define AXI_ADDR_W 32
`endif
`ifndef AXI_LEN_W
`define AXI_LEN_W 8
`endif
`ifndef AXI_SIZE_W
`define AXI_SIZE_W 3
`endif
`ifndef AXI_BURST_W
`define AXI_BURST_W 2
`endif
`ifndef AXI_USER_W
`define AXI_USER_W 4
`endif
`ifndef AXI_DATA_W
`define AXI_DATA_W 32
`endif
`ifndef AXI_RESP_W
`define AXI_RESP_W 2
`endif

module tb_easyaxi_mst_rd_engine;
    localparam int OST = 8;
    localparam int MBL = 8;
    localparam int DW  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 0, cmd_ready;
    logic [31:0]   cmd_addr = 0;
    logic [2:0]    cmd_len = 0, cmd_size = 0;
    logic [1:0]    cmd_burst = 0;
    logic [3:0]    cmd_user = 0;
    logic          arvalid, arready = 0;
    logic [3:0]    arid, aruser;
    logic [31:0]   araddr;
    logic [7:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          rvalid = 0, rready, rlast = 0;
    logic [3:0]    rid = 0, ruser = 0;
    logic [31:0]   rdata = 0;
    logic [1:0]    rresp = 0;
    logic          cmp_valid, cmp_ready = 0, cmp_err, proto_err;
    logic [2:0]    cmp_slot;
    logic [DW*MBL-1:0] cmp_data;
    logic [3:0]    cmp_beats, ost_cnt;
    logic [1:0]    cmp_resp;

    easyaxi_mst_rd_engine #(.OST_DEPTH(OST), .MAX_BURST_LEN(MBL)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_user(cmd_user),
        .axi_mst_arvalid(arvalid), .axi_mst_arready(arready), .axi_mst_arid(arid),
        .axi_mst_araddr(araddr), .axi_mst_arlen(arlen), .axi_mst_arsize(arsize),
        .axi_mst_arburst(arburst), .axi_mst_aruser(aruser),
        .axi_mst_rvalid(rvalid), .axi_mst_rready(rready), .axi_mst_rid(rid),
        .axi_mst_rdata(rdata), .axi_mst_rresp(rresp), .axi_mst_rlast(rlast), .axi_mst_ruser(ruser),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_slot(cmp_slot), .cmp_data(cmp_data),
        .cmp_beats(cmp_beats), .cmp_resp(cmp_resp), .cmp_err(cmp_err),
        .ost_cnt(ost_cnt), .proto_err(proto_err)
    );

    int checks = 0;
    int errors = 0;

    // Transaction model: what each slot was asked for and which beats the bench sent to it.
    logic [31:0] m_addr [OST];
    int          m_len  [OST];
    logic [2:0]  m_size [OST];
    logic [1:0]  m_burst[OST];
    logic [3:0]  m_user [OST];
    logic [DW-1:0] m_data [OST][MBL];
    int          m_sent [OST];
    int          m_resp [OST];
    int          ar_q[$];
    int          r_q[$];
    int          cmp_q[$];
    int          next_slot;

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic clear_model();
        ar_q.delete(); r_q.delete(); cmp_q.delete();
        next_slot = 0;
    endtask

    task automatic do_reset();
        rst = 1; cmd_valid = 0; arready = 0; rvalid = 0; rlast = 0; cmp_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(posedge clk); #1;
        clear_model();
    endtask

    task automatic do_cmd(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] user);
        int n = 0;
        int s;
        cmd_valid = 1; cmd_addr = addr; cmd_len = 3'(len);
        cmd_size = size; cmd_burst = burst; cmd_user = user;
        while (cmd_ready !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL cmd_accept timeout got cmd_ready=%b exp 1", cmd_ready);
            cmd_valid = 0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 0;
        s = next_slot;
        m_addr[s] = addr; m_len[s] = len; m_size[s] = size; m_burst[s] = burst; m_user[s] = user;
        m_sent[s] = 0; m_resp[s] = 0;
        ar_q.push_back(s); cmp_q.push_back(s);
        next_slot = (next_slot + 1) % OST;
    endtask

    task automatic do_ar(input int hold);
        int n = 0;
        int s;
        logic [52:0] got, exp;
        if (ar_q.size() == 0) return;
        s = ar_q[0];
        arready = 0;
        while (arvalid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL ar_valid timeout got %b exp 1", arvalid);
            return;
        end
        for (int i = 0; i <= hold; i++) begin
            exp = {4'(s), m_addr[s], 8'(m_len[s]), m_size[s], m_burst[s], m_user[s]};
            got = {arid, araddr, arlen, arsize, arburst, aruser};
            checks++;
            if (arvalid !== 1'b1 || got !== exp) begin
                errors++;
                $display("FAIL ar_fields got v=%b %h exp v=1 %h", arvalid, got, exp);
            end
            if (i == hold) arready = 1;
            @(posedge clk); #1;
        end
        arready = 0;
        void'(ar_q.pop_front());
        r_q.push_back(s);
    endtask

    task automatic send_beat(input int id, input logic [DW-1:0] d, input logic [1:0] resp,
                             input bit last, input bit good);
        rvalid = 1; rid = 4'(id); rdata = d; rresp = resp; rlast = last; ruser = 4'($urandom);
        @(posedge clk); #1;
        rvalid = 0; rlast = 0;
        if (good) begin
            if (m_sent[id] < MBL) begin
                m_data[id][m_sent[id]] = d;
                if (int'(resp) > m_resp[id]) m_resp[id] = int'(resp);
            end
            m_sent[id]++;
            if (last)
                for (int i = 0; i < r_q.size(); i++)
                    if (r_q[i] == id) begin r_q.delete(i); break; end
        end
    endtask

    task automatic send_burst(input int s, input int nbeats, input int slverr_idx);
        for (int i = 0; i < nbeats; i++)
            send_beat(s, $urandom, (i == slverr_idx) ? 2'b10 : 2'b00, i == nbeats - 1, 1'b1);
    endtask

    task automatic send_interleaved();
        int rem[OST];
        int lst[$];
        int k;
        int s;
        lst = r_q;
        foreach (lst[i]) rem[lst[i]] = m_len[lst[i]] + 1;
        while (lst.size() > 0) begin
            k = $urandom_range(0, lst.size() - 1);
            s = lst[k];
            rem[s]--;
            send_beat(s, $urandom, 2'($urandom_range(0, 3)), rem[s] == 0, 1'b1);
            if (rem[s] == 0) lst.delete(k);
        end
    endtask

    task automatic check_cmp(input int stall);
        int n = 0;
        int s;
        int exp_beats;
        bit exp_err;
        logic [DW*MBL-1:0] exp_data;
        if (cmp_q.size() == 0) return;
        s = cmp_q[0];
        cmp_ready = 0;
        while (cmp_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL cmp_valid timeout got %b exp 1", cmp_valid);
            return;
        end
        exp_beats = (m_sent[s] < MBL) ? m_sent[s] : MBL;
        exp_err   = (m_sent[s] != m_len[s] + 1);
        exp_data  = '0;
        for (int k = 0; k < exp_beats; k++) exp_data[k*DW +: DW] = m_data[s][k];
        for (int i = 0; i <= stall; i++) begin
            checks++;
            if (cmp_valid !== 1'b1 || cmp_slot !== 3'(s)) begin
                errors++;
                $display("FAIL cmp_slot got v=%b %0d exp v=1 %0d", cmp_valid, cmp_slot, s);
            end
            checks++;
            if (cmp_data !== exp_data) begin
                errors++;
                $display("FAIL cmp_data slot %0d got %h exp %h", s, cmp_data, exp_data);
            end
            checks++;
            if (cmp_beats !== 4'(exp_beats)) begin
                errors++;
                $display("FAIL cmp_beats slot %0d got %0d exp %0d", s, cmp_beats, exp_beats);
            end
            checks++;
            if (cmp_resp !== 2'(m_resp[s]) || cmp_err !== exp_err) begin
                errors++;
                $display("FAIL cmp_resp_err slot %0d got %0d/%b exp %0d/%b",
                         s, cmp_resp, cmp_err, m_resp[s], exp_err);
            end
            if (i == stall) cmp_ready = 1;
            @(posedge clk); #1;
        end
        cmp_ready = 0;
        void'(cmp_q.pop_front());
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk); #1;
        checks++;
        if ({cmd_ready, arvalid, cmp_valid, cmp_err, proto_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000", {cmd_ready, arvalid, cmp_valid, cmp_err, proto_err});
        end
        checks++;
        if (ost_cnt !== 4'd0 || cmp_data !== '0 || araddr !== 32'd0) begin
            errors++;
            $display("FAIL reset_state got ost=%0d data=%h addr=%h exp 0", ost_cnt, cmp_data, araddr);
        end
        rst = 0; #1;
        checks++;
        if (cmd_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b exp 0", cmd_ready); end
        @(posedge clk); #1;
        checks++;
        if (cmd_ready !== 1'b1 || rready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_edge got %b%b exp 11", cmd_ready, rready);
        end
        clear_model();
    endtask

    task automatic test_single();
        do_reset();
        do_cmd(32'h100, 3, 3'd2, 2'b01, 4'h0);
        checks++;
        if (arvalid !== 1'b1 || arid !== 4'd0 || arlen !== 8'd3) begin
            errors++;
            $display("FAIL single_ar got v=%b id=%0d len=%0d exp 1 0 3", arvalid, arid, arlen);
        end
        do_ar(0);
        checks++;
        if (cmp_valid !== 1'b0) begin errors++; $display("FAIL single_early_cmp got %b exp 0", cmp_valid); end
        send_burst(0, 4, -1);
        checks++;
        if (cmp_valid !== 1'b1 || cmp_beats !== 4'd4 || cmp_resp !== 2'b00 || cmp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_cmp got v=%b beats=%0d resp=%0d err=%b exp 1 4 0 0",
                     cmp_valid, cmp_beats, cmp_resp, cmp_err);
        end
        check_cmp(0);
        checks++;
        if (ost_cnt !== 4'd0) begin errors++; $display("FAIL single_ost got %0d exp 0", ost_cnt); end
    endtask

    task automatic test_reorder();
        do_reset();
        for (int i = 0; i < 3; i++)
            do_cmd($urandom, $urandom_range(0, 7), 3'd2, 2'b01, 4'($urandom));
        repeat (3) do_ar($urandom_range(0, 2));
        send_burst(2, m_len[2] + 1, -1);
        send_burst(0, m_len[0] + 1, -1);
        send_burst(1, m_len[1] + 1, -1);
        repeat (3) check_cmp(0);
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < OST; i++)
            do_cmd($urandom, $urandom_range(0, 7), 3'd2, 2'b01, 4'($urandom));
        checks++;
        if (ost_cnt !== 4'd8 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_state got ost=%0d ready=%b exp 8 0", ost_cnt, cmd_ready);
        end
        cmd_valid = 1;
        repeat (3) @(posedge clk); #1;
        cmd_valid = 0;
        checks++;
        if (ost_cnt !== 4'd8 || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_hold got ost=%0d ready=%b exp 8 0", ost_cnt, cmd_ready);
        end
        do_ar(0);
        send_burst(cmp_q[0], m_len[cmp_q[0]] + 1, -1);
        check_cmp(0);
        checks++;
        if (cmd_ready !== 1'b1 || ost_cnt !== 4'd7) begin
            errors++;
            $display("FAIL full_release got ready=%b ost=%0d exp 1 7", cmd_ready, ost_cnt);
        end
        do_cmd($urandom, $urandom_range(0, 7), 3'd2, 2'b01, 4'h3);
        while (ar_q.size() > 0) do_ar($urandom_range(0, 2));
        send_interleaved();
        while (cmp_q.size() > 0) check_cmp(0);
    endtask

    task automatic test_error();
        do_reset();
        do_cmd(32'h2000, 0, 3'd2, 2'b01, 4'h1);
        do_cmd(32'h3000, 3, 3'd2, 2'b01, 4'h2);
        do_cmd(32'h4000, MBL - 1, 3'd2, 2'b01, 4'h3);
        repeat (3) do_ar(0);
        send_burst(1, 3, 1);
        send_burst(0, 1, -1);
        send_burst(2, MBL + 2, -1);
        check_cmp(0);
        checks++;
        if (cmp_slot !== 3'd1 || cmp_resp !== 2'b10 || cmp_beats !== 4'd3 || cmp_err !== 1'b1) begin
            errors++;
            $display("FAIL error_short got slot=%0d resp=%0d beats=%0d err=%b exp 1 2 3 1",
                     cmp_slot, cmp_resp, cmp_beats, cmp_err);
        end
        check_cmp(1);
        checks++;
        if (cmp_beats !== 4'd8 || cmp_err !== 1'b1) begin
            errors++;
            $display("FAIL error_overflow got beats=%0d err=%b exp 8 1", cmp_beats, cmp_err);
        end
        check_cmp(0);
    endtask

    task automatic test_protocol();
        do_reset();
        send_beat(5, $urandom, 2'b00, 1'b1, 1'b0);
        checks++;
        if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_set got %b exp 1", proto_err); end
        repeat (5) @(posedge clk); #1;
        checks++;
        if (proto_err !== 1'b1 || ost_cnt !== 4'd0 || cmp_valid !== 1'b0) begin
            errors++;
            $display("FAIL proto_sticky got %b ost=%0d cv=%b exp 1 0 0", proto_err, ost_cnt, cmp_valid);
        end
        do_reset();
        checks++;
        if (proto_err !== 1'b0) begin errors++; $display("FAIL proto_clear got %b exp 0", proto_err); end
        do_cmd(32'h500, 2, 3'd2, 2'b01, 4'h0);
        do_ar(0);
        send_beat(8, $urandom, 2'b10, 1'b1, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || cmp_valid !== 1'b0) begin
            errors++;
            $display("FAIL proto_rid_hi got pe=%b cv=%b exp 1 0", proto_err, cmp_valid);
        end
        send_burst(0, 3, -1);
        check_cmp(1);
        do_cmd(32'h600, 1, 3'd2, 2'b01, 4'h0);
        do_ar(0);
        do_reset();
        checks++;
        if (proto_err !== 1'b0 || ost_cnt !== 4'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_reset got pe=%b ost=%0d rdy=%b exp 0 0 1", proto_err, ost_cnt, cmd_ready);
        end
        send_beat(1, $urandom, 2'b00, 1'b1, 1'b0);
        checks++;
        if (proto_err !== 1'b1 || cmp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_beat got pe=%b cv=%b exp 1 0", proto_err, cmp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int issued = 0;
        int batch;
        do_reset();
        while (issued < 20) begin
            batch = $urandom_range(1, 5);
            for (int b = 0; b < batch && issued < 20; b++) begin
                do_cmd($urandom, $urandom_range(0, 7), 3'($urandom), 2'($urandom), 4'($urandom));
                issued++;
            end
            while (ar_q.size() > 0) do_ar($urandom_range(0, 2));
            send_interleaved();
            while (cmp_q.size() > 0) check_cmp($urandom_range(0, 3));
        end
        checks++;
        if (ost_cnt !== 4'd0 || cmd_ready !== 1'b1 || proto_err !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got ost=%0d rdy=%b pe=%b exp 0 1 0", ost_cnt, cmd_ready, proto_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reorder();
        test_full();
        test_error();
        test_protocol();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
